// File: rtl/aes_cbc_stream_framer.sv
// aes_cbc_stream_framer
//   Feeds the iterative AES-256-CBC core. After a one-shot config handshake it
//   emits 128-bit beats in this order: key[127:0], key[255:128], IV, then the
//   payload packed four 32-bit words per block. tuser carries the encrypt
//   flag on every beat, and tlast marks the final block of the message.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   cfg_valid/cfg_ready   config handshake (ready only while idle)
//   cfg_key/iv/encrypt    AES-256 key, IV, direction (1 = encrypt)
//   s_axis_*              32-bit payload in, [31:24] is the earliest byte,
//                         tkeep left-justified and honoured on tlast only
//   m_axis_*              128-bit beats to the core, all registered
//   busy                  high whenever the framer is not idle
//
// Build option
//   AES_FRAMER_PKCS7_EN   when defined, encrypt messages get PKCS#7 padding
//                         (a full pad block when the message ends on a block
//                         boundary). Decrypt messages are never padded.
module aes_cbc_stream_framer (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [255:0] cfg_key,
    input  logic [127:0] cfg_iv,
    input  logic         cfg_encrypt,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic [31:0]  s_axis_tdata,
    input  logic [3:0]   s_axis_tkeep,
    input  logic         s_axis_tlast,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [127:0] m_axis_tdata,
    output logic [15:0]  m_axis_tkeep,
    output logic         m_axis_tlast,
    output logic         m_axis_tuser,
    output logic         busy
);
    localparam int WORDS_PER_BLOCK = 4;
    localparam int BYTE_CNT_W      = 5;

`ifdef AES_FRAMER_PKCS7_EN
    localparam logic PKCS7_EN = 1'b1;
`else
    localparam logic PKCS7_EN = 1'b0;
`endif

    typedef enum logic [6:0] {
        ST_IDLE   = 7'b0000001,
        ST_KEY_LO = 7'b0000010,
        ST_KEY_HI = 7'b0000100,
        ST_IV     = 7'b0001000,
        ST_FILL   = 7'b0010000,
        ST_BLOCK  = 7'b0100000,
        ST_PAD    = 7'b1000000
    } state_t;

    state_t                  state_reg, state_next;
    logic [127:0]            key_hi_reg, key_hi_next;
    logic [127:0]            iv_reg, iv_next;
    logic                    enc_reg, enc_next;
    logic [127:0]            block_reg, block_next;
    logic [1:0]              word_idx_reg, word_idx_next;
    logic [BYTE_CNT_W-1:0]   byte_cnt_reg, byte_cnt_next;
    logic                    last_reg, last_next;
    logic                    pad_pending_reg, pad_pending_next;
    logic                    tvalid_reg, tvalid_next;
    logic [127:0]            tdata_reg, tdata_next;
    logic [15:0]             tkeep_reg, tkeep_next;
    logic                    tlast_reg, tlast_next;
    logic                    tuser_reg, tuser_next;

    // Valid byte count of the incoming word: 4 unless it is the tlast word,
    // where 0000 means a full word and anything else counts leading ones.
    logic [2:0] word_bytes;
    always_comb begin
        word_bytes = 3'd4;
        if (s_axis_tlast && s_axis_tkeep != 4'b0000) begin
            if (!s_axis_tkeep[3])      word_bytes = 3'd0;
            else if (!s_axis_tkeep[2]) word_bytes = 3'd1;
            else if (!s_axis_tkeep[1]) word_bytes = 3'd2;
            else if (!s_axis_tkeep[0]) word_bytes = 3'd3;
        end
    end

    logic [31:0] word_masked;
    for (genvar gi = 0; gi < 4; gi++) begin : g_word_lane
        assign word_masked[31-8*gi -: 8] =
            (3'(gi) < word_bytes) ? s_axis_tdata[31-8*gi -: 8] : 8'h00;
    end

    logic [127:0] block_filled;
    always_comb begin
        block_filled = block_reg;
        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
            if (word_idx_reg == 2'(k)) block_filled[127-32*k -: 32] = word_masked;
        end
    end

    logic [BYTE_CNT_W-1:0] byte_total;
    logic                  do_pad;
    logic                  pad_after;
    logic [7:0]            pad_byte;
    logic [127:0]          block_out;
    logic [15:0]           keep_out;
    logic [15:0]           lane_valid;

    assign byte_total = byte_cnt_reg + {2'b00, word_bytes};
    assign do_pad     = PKCS7_EN && enc_reg && s_axis_tlast;
    assign pad_byte   = 8'd16 - {3'b000, byte_total};
    // A message ending exactly on a block boundary still needs a pad block.
    assign pad_after  = do_pad && (byte_total == 5'd16);

    // Byte lane gi of the outgoing block sits at [127-8*gi -: 8].
    for (genvar gi = 0; gi < 16; gi++) begin : g_block_lane
        assign lane_valid[gi] = (5'(gi) < byte_total);
        assign block_out[127-8*gi -: 8] = lane_valid[gi] ? block_filled[127-8*gi -: 8]
                                        : (do_pad ? pad_byte : 8'h00);
        assign keep_out[15-gi] = lane_valid[gi] | do_pad;
    end

    logic beat_done;
    assign beat_done = tvalid_reg && m_axis_tready;

    always_comb begin
        state_next       = state_reg;
        key_hi_next      = key_hi_reg;
        iv_next          = iv_reg;
        enc_next         = enc_reg;
        block_next       = block_reg;
        word_idx_next    = word_idx_reg;
        byte_cnt_next    = byte_cnt_reg;
        last_next        = last_reg;
        pad_pending_next = pad_pending_reg;
        tvalid_next      = tvalid_reg;
        tdata_next       = tdata_reg;
        tkeep_next       = tkeep_reg;
        tlast_next       = tlast_reg;
        tuser_next       = tuser_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cfg_valid) begin
                    key_hi_next = cfg_key[255:128];
                    iv_next     = cfg_iv;
                    enc_next    = cfg_encrypt;
                    tuser_next  = cfg_encrypt;
                    tvalid_next = 1'b1;
                    tdata_next  = cfg_key[127:0];
                    tkeep_next  = 16'hFFFF;
                    tlast_next  = 1'b0;
                    state_next  = ST_KEY_LO;
                end
            end
            ST_KEY_LO: begin
                if (beat_done) begin
                    tdata_next = key_hi_reg;
                    state_next = ST_KEY_HI;
                end
            end
            ST_KEY_HI: begin
                if (beat_done) begin
                    tdata_next = iv_reg;
                    state_next = ST_IV;
                end
            end
            ST_IV: begin
                if (beat_done) begin
                    tvalid_next      = 1'b0;
                    word_idx_next    = 2'd0;
                    byte_cnt_next    = '0;
                    block_next       = '0;
                    last_next        = 1'b0;
                    pad_pending_next = 1'b0;
                    state_next       = ST_FILL;
                end
            end
            ST_FILL: begin
                if (s_axis_tvalid) begin
                    block_next    = block_filled;
                    byte_cnt_next = byte_total;
                    word_idx_next = word_idx_reg + 2'd1;
                    if (word_idx_reg == 2'(WORDS_PER_BLOCK-1) || s_axis_tlast) begin
                        tvalid_next      = 1'b1;
                        tdata_next       = block_out;
                        tkeep_next       = keep_out;
                        tlast_next       = s_axis_tlast && !pad_after;
                        last_next        = s_axis_tlast;
                        pad_pending_next = pad_after;
                        state_next       = ST_BLOCK;
                    end
                end
            end
            ST_BLOCK: begin
                if (beat_done) begin
                    if (pad_pending_reg) begin
                        tdata_next       = {16{8'h10}};
                        tkeep_next       = 16'hFFFF;
                        tlast_next       = 1'b1;
                        pad_pending_next = 1'b0;
                        state_next       = ST_PAD;
                    end else if (last_reg) begin
                        tvalid_next = 1'b0;
                        tlast_next  = 1'b0;
                        state_next  = ST_IDLE;
                    end else begin
                        tvalid_next   = 1'b0;
                        word_idx_next = 2'd0;
                        byte_cnt_next = '0;
                        block_next    = '0;
                        state_next    = ST_FILL;
                    end
                end
            end
            ST_PAD: begin
                if (beat_done) begin
                    tvalid_next = 1'b0;
                    tlast_next  = 1'b0;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            key_hi_reg      <= '0;
            iv_reg          <= '0;
            enc_reg         <= 1'b0;
            block_reg       <= '0;
            word_idx_reg    <= '0;
            byte_cnt_reg    <= '0;
            last_reg        <= 1'b0;
            pad_pending_reg <= 1'b0;
            tvalid_reg      <= 1'b0;
            tdata_reg       <= '0;
            tkeep_reg       <= '0;
            tlast_reg       <= 1'b0;
            tuser_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            key_hi_reg      <= key_hi_next;
            iv_reg          <= iv_next;
            enc_reg         <= enc_next;
            block_reg       <= block_next;
            word_idx_reg    <= word_idx_next;
            byte_cnt_reg    <= byte_cnt_next;
            last_reg        <= last_next;
            pad_pending_reg <= pad_pending_next;
            tvalid_reg      <= tvalid_next;
            tdata_reg       <= tdata_next;
            tkeep_reg       <= tkeep_next;
            tlast_reg       <= tlast_next;
            tuser_reg       <= tuser_next;
        end
    end

    // Config ready is forced low during reset, not just by the idle state.
    assign cfg_ready     = (state_reg == ST_IDLE) && !rst;
    assign s_axis_tready = (state_reg == ST_FILL);
    assign busy          = (state_reg != ST_IDLE);
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tkeep  = tkeep_reg;
    assign m_axis_tlast  = tlast_reg;
    assign m_axis_tuser  = tuser_reg;
endmodule

// File: tb/tb_aes_cbc_stream_framer.sv
module tb_aes_cbc_stream_framer;
    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [255:0] cfg_key;
    logic [127:0] cfg_iv;
    logic         cfg_encrypt;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [31:0]  s_axis_tdata;
    logic [3:0]   s_axis_tkeep;
    logic         s_axis_tlast;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic         m_axis_tuser;
    logic         busy;

    always #5 clk = ~clk;

    aes_cbc_stream_framer dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key),
        .cfg_iv(cfg_iv), .cfg_encrypt(cfg_encrypt),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .busy(busy)
    );

`ifdef AES_FRAMER_PKCS7_EN
    localparam bit PKCS = 1'b1;
`else
    localparam bit PKCS = 1'b0;
`endif

    localparam logic [255:0] PLAN_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PLAN_IV  = {16{8'hA5}};
    localparam logic [127:0] BLK0     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] BLK1     = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PADBLK   = {16{8'h10}};

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic         user;
    } beat_t;

    typedef struct {
        int           nwords;
        logic [3:0]   lkeep;
        logic         enc;
        bit           deadbeef;
        bit           stall;
        int           exp_beats;
        logic [127:0] exp_data;
        logic [15:0]  exp_keep;
        logic         exp_last;
    } vec_t;

    int total = 0;
    int bad   = 0;

    beat_t        exp_q[$];
    logic [31:0]  msg[$];
    logic [3:0]   msg_lkeep;
    logic [255:0] key;
    logic [127:0] iv;
    logic         enc;

    int           obs_n;
    logic [127:0] obs_d0, obs_d1, obs_last_d;
    logic [15:0]  obs_last_k;
    logic         obs_last_l;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int keep_bytes(input logic [3:0] k);
        int n;
        if (k == 4'b0000) return 4;
        n = 0;
        while (n < 4 && k[3-n]) n++;
        return n;
    endfunction

    function automatic logic [31:0] plan_word(input int i);
        return {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    endfunction

    // Expected beats from the message as a flat byte stream cut into 16-byte blocks.
    function automatic void build_exp();
        logic [7:0]  b[$];
        logic [31:0] w;
        int          nb, tot, nblk, r;
        bit          fin, padb;
        beat_t       e;
        exp_q.delete();
        e.keep = 16'hFFFF; e.last = 1'b0; e.user = enc;
        e.data = key[127:0];   exp_q.push_back(e);
        e.data = key[255:128]; exp_q.push_back(e);
        e.data = iv;           exp_q.push_back(e);
        for (int i = 0; i < msg.size(); i++) begin
            w  = msg[i];
            nb = (i == msg.size() - 1) ? keep_bytes(msg_lkeep) : 4;
            for (int j = 0; j < nb; j++) b.push_back(w[31-8*j -: 8]);
        end
        tot  = b.size();
        nblk = (tot + 15) / 16;
        for (int blk = 0; blk < nblk; blk++) begin
            r    = tot - 16*blk;
            if (r > 16) r = 16;
            fin  = (blk == nblk - 1);
            padb = fin && PKCS && enc;
            e.keep = 16'h0000;
            for (int j = 0; j < 16; j++) begin
                if (j < r) begin
                    e.data[127-8*j -: 8] = b[16*blk + j];
                    e.keep[15-j] = 1'b1;
                end else begin
                    e.data[127-8*j -: 8] = padb ? 8'(16 - r) : 8'h00;
                    e.keep[15-j] = padb;
                end
            end
            e.last = fin && !(padb && r == 16);
            exp_q.push_back(e);
            if (padb && r == 16) begin
                e.data = PADBLK; e.keep = 16'hFFFF; e.last = 1'b1;
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic cfg_start();
        @(negedge clk);
        cfg_valid = 1'b1; cfg_key = key; cfg_iv = iv; cfg_encrypt = enc;
        check("cfg_ready_idle", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("tvalid_latency", m_axis_tvalid, 1);
    endtask

    task automatic run_msg(input bit rnd, input bit stall);
        int    wi, cycles, stall_left;
        bit    held;
        beat_t hv, e;
        build_exp();
        obs_n = 0; wi = 0; cycles = 0; stall_left = 3; held = 0;
        cfg_start();
        while ((exp_q.size() > 0 || wi < msg.size()) && cycles < 1000) begin
            s_axis_tvalid = (wi < msg.size()) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            s_axis_tdata  = (wi < msg.size()) ? msg[wi] : $urandom;
            s_axis_tlast  = (wi == msg.size() - 1);
            s_axis_tkeep  = s_axis_tlast ? msg_lkeep : (rnd ? 4'($urandom) : 4'hF);
            if (stall && m_axis_tvalid && obs_n == 3 && stall_left > 0) begin
                m_axis_tready = 1'b0;
                stall_left--;
            end else begin
                m_axis_tready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (held)
                check("hold_stable", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
                      {1'b1, hv.data, hv.keep, hv.last, hv.user});
            if (m_axis_tvalid) check("no_overlap", s_axis_tready, 0);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
                          {e.data, e.keep, e.last, e.user});
                end
                if (obs_n == 0) obs_d0 = m_axis_tdata;
                if (obs_n == 1) obs_d1 = m_axis_tdata;
                obs_last_d = m_axis_tdata; obs_last_k = m_axis_tkeep; obs_last_l = m_axis_tlast;
                obs_n++;
            end
            held = m_axis_tvalid && !m_axis_tready;
            hv.data = m_axis_tdata; hv.keep = m_axis_tkeep; hv.last = m_axis_tlast; hv.user = m_axis_tuser;
            if (s_axis_tvalid && s_axis_tready) wi++;
            @(negedge clk);
            cycles++;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        if (cycles >= 1000) begin
            check("msg_timeout", cycles, 0);
            exp_q.delete();
        end
        check("end_idle", {busy, cfg_ready, m_axis_tvalid}, {1'b0, 1'b1, 1'b0});
    endtask

    vec_t vecs[5];
    logic [3:0] legal_keep[5];

    initial begin
        int nb, wi;
        bit found;

        rst = 1'b1; cfg_valid = 0; cfg_key = 0; cfg_iv = 0; cfg_encrypt = 0;
        s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tkeep = 0; s_axis_tlast = 0;
        m_axis_tready = 0;
        legal_keep[0] = 4'hF; legal_keep[1] = 4'hE; legal_keep[2] = 4'hC;
        legal_keep[3] = 4'h8; legal_keep[4] = 4'h0;

        vecs[0] = '{8, 4'hF, 1'b1, 0, 0, PKCS ? 6 : 5, PKCS ? PADBLK : BLK1, 16'hFFFF, 1'b1};
        vecs[1] = '{8, 4'hF, 1'b1, 0, 1, PKCS ? 6 : 5, PKCS ? PADBLK : BLK1, 16'hFFFF, 1'b1};
        vecs[2] = '{5, 4'hC, 1'b1, 1, 0, 5,
                    PKCS ? 128'hDEAD0E0E0E0E0E0E0E0E0E0E0E0E0E0E : 128'hDEAD0000000000000000000000000000,
                    PKCS ? 16'hFFFF : 16'hC000, 1'b1};
        vecs[3] = '{4, 4'hF, 1'b1, 0, 0, PKCS ? 5 : 4, PKCS ? PADBLK : BLK0, 16'hFFFF, 1'b1};
        vecs[4] = '{4, 4'hF, 1'b0, 0, 0, 4, BLK0, 16'hFFFF, 1'b1};

        #12;
        check("rst_m_outputs", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 0);
        check("rst_readys", {s_axis_tready, cfg_ready, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_cfg_ready", cfg_ready, 1);

        key = PLAN_KEY; iv = PLAN_IV;
        for (int v = 0; v < 5; v++) begin
            enc = vecs[v].enc;
            msg.delete();
            for (int i = 0; i < vecs[v].nwords; i++) msg.push_back(plan_word(i));
            if (vecs[v].deadbeef) msg[msg.size()-1] = 32'hDEADBEEF;
            msg_lkeep = vecs[v].lkeep;
            run_msg(0, vecs[v].stall);
            check("vec_beats", obs_n, vecs[v].exp_beats);
            check("vec_final", {obs_last_d, obs_last_k, obs_last_l},
                  {vecs[v].exp_data, vecs[v].exp_keep, vecs[v].exp_last});
            check("vec_key_lo", obs_d0, BLK1);
            check("vec_key_hi", obs_d1, BLK0);
            $display("vector %0d: words=%0d enc=%0d beats=%0d", v, vecs[v].nwords, vecs[v].enc, obs_n);
        end

        // Reset while a text block is being presented and the core stalls.
        key = PLAN_KEY; iv = PLAN_IV; enc = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_key = key; cfg_iv = iv; cfg_encrypt = enc;
        @(negedge clk);
        cfg_valid = 1'b0;
        nb = 0; wi = 0; found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (nb == 3 && m_axis_tvalid) begin
                m_axis_tready = 1'b0;
                s_axis_tvalid = 1'b0;
                found = 1;
            end else begin
                s_axis_tvalid = (wi < 4);
                s_axis_tdata  = plan_word(wi);
                s_axis_tlast  = (wi == 3);
                s_axis_tkeep  = 4'hF;
                m_axis_tready = 1'b1;
                if (m_axis_tvalid) nb++;
                if (s_axis_tvalid && s_axis_tready) wi++;
                @(negedge clk);
            end
        end
        check("rst_setup_reached_block", {found, m_axis_tlast}, {1'b1, 1'b1});
        #2 rst = 1'b1;
        #1;
        check("rst_mid_drop", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep}, 0);
        check("rst_mid_readys", {cfg_ready, s_axis_tready, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release", {cfg_ready, busy}, {1'b1, 1'b0});
        enc = 1'b1;
        msg.delete();
        for (int i = 0; i < 8; i++) msg.push_back(plan_word(i));
        msg_lkeep = 4'hF;
        run_msg(0, 0);
        check("after_rst_key_lo", obs_d0, BLK1);
        check("after_rst_beats", obs_n, PKCS ? 6 : 5);
        $display("reset sequence: beats after restart=%0d", obs_n);

        // Randomised messages against the byte-stream model.
        for (int t = 0; t < 40; t++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            iv  = {$urandom, $urandom, $urandom, $urandom};
            enc = 1'($urandom);
            msg.delete();
            for (int i = 0; i < $urandom_range(1, 12); i++) msg.push_back($urandom);
            msg_lkeep = legal_keep[$urandom_range(0, 4)];
            run_msg(1, 0);
            $display("random %0d: words=%0d keep=%h enc=%0d beats=%0d", t, msg.size(), msg_lkeep, enc, obs_n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
